// File: rtl/sram_bus_pkg.sv
// sram_bus_pkg: shared state encoding and constants for the SRAM bus arbiter.
package sram_bus_pkg;
    localparam int STRB_W = 4;
    localparam int DEFAULT_TIMEOUT = 255;
    typedef enum logic [2:0] {S_IDLE, S_D_REQ, S_D_WAIT, S_I_REQ, S_I_WAIT, S_DONE} state_t;
endpackage

// File: rtl/sram_bus_watchdog.sv
// sram_bus_watchdog: counts cycles spent in one busy state and fires on the last allowed one.
module sram_bus_watchdog
    import sram_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic resetn,
    input  logic active,
    input  logic clr,
    output logic fire
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    logic [W-1:0] cnt;
    // Firing on the last count lets the arbiter advance on the edge the count would reach TIMEOUT.
    assign fire = active && cnt == LAST;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else cnt <= (active && !clr) ? cnt + 1'b1 : '0;
    end
endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: serialises data then instruction SRAM requests onto one
// req/addr_ok/data_ok memory port, one outstanding transaction at a time.
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_en,
    input  logic [STRB_W-1:0] data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              stall,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t state;
    logic pend_inst, is_req, is_wait, accept, resp, fire, done, adv;

    always_comb begin
        is_req = state == S_D_REQ || state == S_I_REQ;
        is_wait = state == S_D_WAIT || state == S_I_WAIT;
        accept = is_req && mem_addr_ok;
        resp = mem_data_ok && (is_wait || accept);
        done = resp || fire;
        stall = (state == S_IDLE && (inst_en || data_en)) || is_req || is_wait;
        adv = done || accept || state == S_DONE || (state == S_IDLE && (inst_en || data_en));
    end

    sram_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk   (clk),
        .resetn(resetn),
        .active(is_req || is_wait),
        .clr   (adv),
        .fire  (fire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            pend_inst <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
            mem_req <= 1'b0;
            mem_wr <= 1'b0;
            mem_wstrb <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= fire && !resp;
            case (state)
                S_IDLE:
                    if (data_en) begin
                        state <= S_D_REQ;
                        pend_inst <= inst_en;
                        mem_req <= 1'b1;
                        mem_wr <= |data_wen;
                        mem_wstrb <= data_wen;
                        mem_addr <= data_addr;
                        mem_wdata <= data_wdata;
                    end else if (inst_en) begin
                        state <= S_I_REQ;
                        mem_req <= 1'b1;
                        mem_wr <= 1'b0;
                        mem_wstrb <= '0;
                        mem_addr <= inst_addr;
                        mem_wdata <= '0;
                    end
                S_D_REQ, S_D_WAIT:
                    if (done) begin
                        if (!mem_wr) data_rdata <= resp ? mem_rdata : '0;
                        state <= pend_inst ? S_I_REQ : S_DONE;
                        mem_req <= pend_inst;
                        if (pend_inst) begin
                            mem_wr <= 1'b0;
                            mem_wstrb <= '0;
                            mem_addr <= inst_addr;
                            mem_wdata <= '0;
                        end
                    end else if (accept) begin
                        state <= S_D_WAIT;
                        mem_req <= 1'b0;
                    end
                S_I_REQ, S_I_WAIT:
                    if (done) begin
                        inst_rdata <= resp ? mem_rdata : '0;
                        state <= S_DONE;
                        mem_req <= 1'b0;
                    end else if (accept) begin
                        state <= S_I_WAIT;
                        mem_req <= 1'b0;
                    end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
